ram_sp_be_clr: RTL and testbench
================================

# ram_sp_be_clr

Parametrised single-port synchronous RAM: successor to the basic single-port synchronous read/write memory in the memory examples. Adds per-lane byte-enables, a selectable read-during-write mode, an optional output register stage and a clear engine that zeroes the array after reset or on request. Intended as the general-purpose on-chip buffer for small register files and scratchpads.

## Interface
- DATA_WIDTH, 8, word width in bits; must be a multiple of LANE_WIDTH
- LANE_WIDTH, 4, bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH
- ADDR_WIDTH, 4, address width
- RAM_DEPTH, 1 << ADDR_WIDTH, number of words
- RDW_MODE, 0, read-during-write behaviour: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- OUT_REG, 0, 1 adds one output pipeline register
- CLEAR_ON_RESET, 1, 1 starts a full clear when reset is applied
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- addrIn  in  ADDR_WIDTH  access address
- dataIn  in  DATA_WIDTH  write data
- we  in  1  write strobe
- be  in  NUM_LANES  lane enables; lane i covers dataIn[i*LANE_WIDTH +: LANE_WIDTH]
- oe  in  1  read strobe
- clr  in  1  single-cycle clear request
- dataOut  out  DATA_WIDTH  read data
- dataValid  out  1  one-cycle pulse aligned with each new dataOut
- busy  out  1  clear in progress; accesses ignored

## Operation
- Write: at a clk edge with we=1 and busy=0, every lane with be[i]=1 is written at addrIn; lanes with be[i]=0 keep their content. we=1 with be=0 writes nothing.
- Read: oe=1, busy=0 launches a read of addrIn.
- we=1 and oe=1 at the same address (always the same, single port):
  - READ_FIRST: dataOut = pre-write word.
  - WRITE_FIRST: dataOut = merged word (enabled lanes from dataIn, others old).
  - NO_CHANGE: no read launched; dataOut holds and no dataValid pulse.
- dataOut holds its last value between reads.
- Clear FSM, states IDLE and CLEAR, with counter clrAddr (ADDR_WIDTH bits):
  - IDLE -> CLEAR on clr=1. CLEAR writes zero to clrAddr each cycle and increments it. CLEAR -> IDLE on the edge that writes RAM_DEPTH-1.
  - clr while in CLEAR is ignored; no restart.
  - busy = (state == CLEAR); it is registered.
  - we/oe are ignored while busy=1: no write, no read and no dataValid.
- Reset:
  - dataOut=0, dataValid=0 and the output pipeline register are cleared.
  - With CLEAR_ON_RESET=1: state=CLEAR, clrAddr=0, busy=1.
  - With CLEAR_ON_RESET=0: state=IDLE, busy=0, and array contents are not reset.
  - Reset during CLEAR restarts the clear from address 0 (CLEAR_ON_RESET=1) or abandons it (CLEAR_ON_RESET=0).
  - Reads in flight at reset are dropped.

## Timing
- Read latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from the launch edge to dataOut/dataValid.
- Back-to-back reads are fully pipelined, one per cycle.
- Write is visible to a read launched on the next edge.
- A clear takes exactly RAM_DEPTH cycles; busy falls on the edge after the last zero write.
- With CLEAR_ON_RESET=1, the first access is accepted RAM_DEPTH cycles after rst deasserts.
- dataValid is high for exactly one cycle per launched read.

## Structure
- Shared package ram_pkg:
  - RDW_READ_FIRST, RDW_WRITE_FIRST and RDW_NO_CHANGE constants
  - clear-FSM state encoding (ST_IDLE, ST_CLEAR)
  - lane-merge function merge(old, new, be)
- One sub-module, ram_clear_fsm: owns the state, clrAddr and busy. It drives the array write port mux (clear write vs user write).
- Array, read path and optional output stage remain in the top module.

## Test plan
- Reset with defaults: busy=1 for 16 cycles, then busy=0. A subsequent read of each address 0..15 returns 8'h00, with dataValid one cycle after each oe.
- Write addr 3 data 8'hA5 be=2'b11, then write addr 3 data 8'h3C be=2'b01. Read addr 3 -> dataOut=8'hAC.
- Read-during-write, addr 5 holding 8'h11, with we=oe=1, dataIn=8'h22, be=2'b11:
  - RDW_MODE=0 -> 8'h11
  - RDW_MODE=1 -> 8'h22
  - RDW_MODE=2 -> dataOut unchanged, no dataValid
  - memory holds 8'h22 afterwards in all modes
- OUT_REG=1 with consecutive reads of addr 1,2,3 (values 8'h01,8'h02,8'h03) -> the same sequence appears on dataOut, first at 2 cycles after launch, then one per cycle, with dataValid high for 3 cycles.
- clr pulse, then we=1 to addr 7 during busy -> write ignored and addr 7 reads 8'h00. A second clr mid-clear does not extend busy beyond 16 cycles.
- rst asserted at clrAddr=9 during a clear -> busy stays high and a fresh 16-cycle clear completes. dataOut=0 and dataValid=0 after the reset edge.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable single-port RAM: read-during-write modes,
// clear-engine state encoding and the lane-merge helper.
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_MAX_WIDTH = 256;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clrState_e;

  typedef logic [MERGE_MAX_WIDTH-1:0] mergeWord_t;

  // Lanes whose enable bit is set take newWord, the rest keep oldWord.
  function automatic mergeWord_t merge(input mergeWord_t oldWord,
                                       input mergeWord_t newWord,
                                       input mergeWord_t be,
                                       input int         laneWidth);
    mergeWord_t result;
    logic [7:0] lane;
    result = oldWord;
    for (int i = 0; i < MERGE_MAX_WIDTH; i++) begin
      lane = 8'(i / laneWidth);
      if (be[lane]) result[i] = newWord[i];
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: sweeps zeros through the array and arbitrates the array write port
// between the sweep and user writes.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_LANES      = 2,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  userWe,
  input  logic [NUM_LANES-1:0]  userBe,
  input  logic [ADDR_WIDTH-1:0] userAddr,
  input  logic [DATA_WIDTH-1:0] userData,
  output logic                  busy,
  output logic                  memWe,
  output logic [NUM_LANES-1:0]  memBe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memData
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  clrState_e             state, stateNext;
  logic [ADDR_WIDTH-1:0] clrAddr, clrAddrNext;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clrAddr <= '0;
    end else begin
      state   <= stateNext;
      clrAddr <= clrAddrNext;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    stateNext   = state;
    clrAddrNext = clrAddr;
    memWe       = userWe;
    memBe       = userBe;
    memAddr     = userAddr;
    memData     = userData;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          stateNext   = ST_CLEAR;
          clrAddrNext = '0;
        end
      end
      ST_CLEAR: begin
        // User writes are dropped; clr is ignored so a sweep never restarts.
        memWe       = 1'b1;
        memBe       = '1;
        memAddr     = clrAddr;
        memData     = '0;
        clrAddrNext = clrAddr + 1'b1;
        if (clrAddr == LAST_ADDR) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CLEAR);

endmodule

// File: rtl/ram_sp_be_clr.sv
// Single-port synchronous RAM with lane write enables, selectable read-during-write
// behaviour, optional output register and a zeroing clear engine.
module ram_sp_be_clr
  import ram_pkg::*;
#(
  parameter int  DATA_WIDTH     = 8,
  parameter int  LANE_WIDTH     = 4,
  parameter int  ADDR_WIDTH     = 4,
  parameter int  RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int  RDW_MODE       = RDW_READ_FIRST,
  parameter int  OUT_REG        = 0,
  parameter int  CLEAR_ON_RESET = 1,
  localparam int NUM_LANES      = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addrIn,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  we,
  input  logic [NUM_LANES-1:0]  be,
  input  logic                  oe,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  busy
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  memWe;
  logic [NUM_LANES-1:0]  memBe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memData;

  ram_clear_fsm #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_LANES     (NUM_LANES),
    .RAM_DEPTH     (RAM_DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) uClearFsm (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .userWe  (we),
    .userBe  (be),
    .userAddr(addrIn),
    .userData(dataIn),
    .busy    (busy),
    .memWe   (memWe),
    .memBe   (memBe),
    .memAddr (memAddr),
    .memData (memData)
  );

  // NOTE: the array is not reset; the clear engine zeroes it, keeping it mappable to block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (memWe && memBe[i])
        mem[memAddr][i*LANE_WIDTH +: LANE_WIDTH] <= memData[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  logic [DATA_WIDTH-1:0] mergedWord;
  logic                  readLaunch;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  rdValid;

  always_comb begin
    mergedWord = DATA_WIDTH'(merge(mergeWord_t'(mem[addrIn]), mergeWord_t'(dataIn),
                                   mergeWord_t'(be), LANE_WIDTH));
  end

  // NO_CHANGE suppresses the read entirely when it collides with a write.
  assign readLaunch = oe && !busy && !(RDW_MODE == RDW_NO_CHANGE && we);

  always_ff @(posedge clk) begin
    if (rst) begin
      rdData  <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= readLaunch;
      if (readLaunch)
        rdData <= (RDW_MODE == RDW_WRITE_FIRST && we) ? mergedWord : mem[addrIn];
    end
  end

  generate
    if (OUT_REG != 0) begin : gOutReg
      logic [DATA_WIDTH-1:0] outData;
      logic                  outValid;

      always_ff @(posedge clk) begin
        if (rst) begin
          outData  <= '0;
          outValid <= 1'b0;
        end else begin
          outValid <= rdValid;
          if (rdValid) outData <= rdData;
        end
      end

      assign dataOut   = outData;
      assign dataValid = outValid;
    end else begin : gNoOutReg
      assign dataOut   = rdData;
      assign dataValid = rdValid;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sp_be_clr.sv
// Four RAM variants (RDW mode x output register) share one stimulus stream and are
// compared every cycle against a word-array model plus directed constant checks.
module tb_ram_sp_be_clr;

  localparam int DEPTH = 16;
  localparam int NINST = 4;
  localparam int MODE [NINST] = '{0, 1, 2, 0};
  localparam int OREG [NINST] = '{0, 0, 1, 1};

  logic       clk = 1'b0;
  logic       rst, we, oe, clr;
  logic [3:0] addrIn;
  logic [7:0] dataIn;
  logic [1:0] be;

  logic [7:0] dOut   [NINST];
  logic       dValid [NINST];
  logic       dBusy  [NINST];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : gDut
    ram_sp_be_clr #(
      .DATA_WIDTH    (8),
      .LANE_WIDTH    (4),
      .ADDR_WIDTH    (4),
      .RAM_DEPTH     (DEPTH),
      .RDW_MODE      (MODE[g]),
      .OUT_REG       (OREG[g]),
      .CLEAR_ON_RESET(1)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .addrIn   (addrIn),
      .dataIn   (dataIn),
      .we       (we),
      .be       (be),
      .oe       (oe),
      .clr      (clr),
      .dataOut  (dOut[g]),
      .dataValid(dValid[g]),
      .busy     (dBusy[g])
    );
  end

  // Reference model: word array, remaining clear cycles, pending reads with due cycle.
  typedef struct {
    int         inst;
    int         due;
    logic [7:0] val;
  } rd_t;

  logic [7:0] mem [DEPTH];
  int         clearLeft = 0;
  int         cyc = 0;
  rd_t        pend [$];
  logic [7:0] expOut   [NINST];
  logic       expValid [NINST];
  logic       expBusy;

  int vecCount = 0;
  int errCount = 0;

  task automatic model_edge();
    logic [7:0] mask, merged, v;
    int j;
    cyc++;
    for (int k = 0; k < NINST; k++) expValid[k] = 1'b0;
    if (rst) begin
      pend.delete();
      for (int k = 0; k < NINST; k++) expOut[k] = 8'h00;
      clearLeft = DEPTH;
      for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
    end else if (clearLeft > 0) begin
      clearLeft--;
    end else begin
      mask   = {{4{be[1]}}, {4{be[0]}}};
      merged = (dataIn & mask) | (mem[addrIn] & ~mask);
      for (int k = 0; k < NINST; k++) begin
        if (oe && !(MODE[k] == 2 && we)) begin
          v = (MODE[k] == 1 && we) ? merged : mem[addrIn];
          pend.push_back('{inst: k, due: cyc + OREG[k], val: v});
        end
      end
      if (we) mem[addrIn] = merged;
      if (clr) begin
        clearLeft = DEPTH;
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
      end
    end
    j = 0;
    while (j < pend.size()) begin
      if (pend[j].due == cyc) begin
        expOut[pend[j].inst]   = pend[j].val;
        expValid[pend[j].inst] = 1'b1;
        pend.delete(j);
      end else begin
        j++;
      end
    end
    expBusy = (clearLeft > 0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; we = 1'b0; oe = 1'b0; clr = 1'b0;
    be = 2'b00; addrIn = 4'h0; dataIn = 8'h00;
  endtask

  task automatic test_reset();
    int busyCnt = 0;
    set_idle();
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) rst = 1'b0;
      if (c >= 2 && dBusy[0] === 1'b1) busyCnt++;
      tick();
      for (int k = 0; k < NINST; k++) begin
        vecCount++;
        if (dOut[k] !== expOut[k] || dValid[k] !== expValid[k] || dBusy[k] !== expBusy) begin
          errCount++;
          $display("FAIL reset inst%0d cyc%0d: got out=%h valid=%b busy=%b, want out=%h valid=%b busy=%b",
                   k, cyc, dOut[k], dValid[k], dBusy[k], expOut[k], expValid[k], expBusy);
        end
      end
    end
    vecCount++;
    if (busyCnt !== 16) begin
      errCount++;
      $display("FAIL reset_busy_len: got %0d cycles, want 16", busyCnt);
    end
  endtask

  task automatic test_clear_read();
    for (int c = 0; c < 17; c++) begin
      set_idle();
      if (c < 16) begin oe = 1'b1; addrIn = 4'(c); end
      tick();
      for (int k = 0; k < NINST; k++) begin
        vecCount++;
        if (dOut[k] !== expOut[k] || dValid[k] !== expValid[k] || dBusy[k] !== expBusy) begin
          errCount++;
          $display("FAIL clear_read inst%0d cyc%0d: got out=%h valid=%b busy=%b, want out=%h valid=%b busy=%b",
                   k, cyc, dOut[k], dValid[k], dBusy[k], expOut[k], expValid[k], expBusy);
        end
      end
      vecCount++;
      if (dOut[0] !== 8'h00 || dValid[0] !== (c < 16)) begin
        errCount++;
        $display("FAIL clear_read_zero addr%0d: got out=%h valid=%b, want out=00 valid=%b",
                 c, dOut[0], dValid[0], (c < 16));
      end
    end
  endtask

  task automatic test_byte_enable();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      case (c)
        0: begin we = 1'b1; addrIn = 4'd3; dataIn = 8'hA5; be = 2'b11; end
        1: begin we = 1'b1; addrIn = 4'd3; dataIn = 8'h3C; be = 2'b01; end
        2: begin oe = 1'b1; addrIn = 4'd3; end
        default: ;
      endcase
      tick();
      for (int k = 0; k < NINST; k++) begin
        vecCount++;
        if (dOut[k] !== expOut[k] || dValid[k] !== expValid[k] || dBusy[k] !== expBusy) begin
          errCount++;
          $display("FAIL byte_enable inst%0d cyc%0d: got out=%h valid=%b busy=%b, want out=%h valid=%b busy=%b",
                   k, cyc, dOut[k], dValid[k], dBusy[k], expOut[k], expValid[k], expBusy);
        end
      end
      if (c == 2 || c == 3) begin
        vecCount++;
        if (dOut[(c == 2) ? 0 : 3] !== 8'hAC || dValid[(c == 2) ? 0 : 3] !== 1'b1) begin
          errCount++;
          $display("FAIL byte_enable_merge step%0d: got out=%h valid=%b, want out=ac valid=1",
                   c, dOut[(c == 2) ? 0 : 3], dValid[(c == 2) ? 0 : 3]);
        end
      end
    end
  endtask

  task automatic test_rdw();
    for (int c = 0; c < 7; c++) begin
      set_idle();
      case (c)
        0: begin we = 1'b1; addrIn = 4'd5; dataIn = 8'h11; be = 2'b11; end
        1: begin oe = 1'b1; addrIn = 4'd3; end
        2: begin we = 1'b1; oe = 1'b1; addrIn = 4'd5; dataIn = 8'h22; be = 2'b11; end
        4: begin oe = 1'b1; addrIn = 4'd5; end
        default: ;
      endcase
      tick();
      for (int k = 0; k < NINST; k++) begin
        vecCount++;
        if (dOut[k] !== expOut[k] || dValid[k] !== expValid[k] || dBusy[k] !== expBusy) begin
          errCount++;
          $display("FAIL rdw inst%0d cyc%0d: got out=%h valid=%b busy=%b, want out=%h valid=%b busy=%b",
                   k, cyc, dOut[k], dValid[k], dBusy[k], expOut[k], expValid[k], expBusy);
        end
      end
      if (c == 2) begin
        vecCount++;
        if (dOut[0] !== 8'h11 || dOut[1] !== 8'h22 || dValid[0] !== 1'b1 || dValid[1] !== 1'b1) begin
          errCount++;
          $display("FAIL rdw_first: got rf=%h wf=%h valid=%b%b, want rf=11 wf=22 valid=11",
                   dOut[0], dOut[1], dValid[0], dValid[1]);
        end
      end
      if (c == 3) begin
        vecCount++;
        if (dOut[2] !== 8'hAC || dValid[2] !== 1'b0 || dOut[3] !== 8'h11) begin
          errCount++;
          $display("FAIL rdw_no_change: got nc=%h nc_valid=%b rf_reg=%h, want nc=ac nc_valid=0 rf_reg=11",
                   dOut[2], dValid[2], dOut[3]);
        end
      end
      if (c == 5) begin
        vecCount++;
        if (dOut[0] !== 8'h22 || dOut[1] !== 8'h22 || dOut[2] !== 8'h22 || dOut[3] !== 8'h22) begin
          errCount++;
          $display("FAIL rdw_after: got %h %h %h %h, want 22 in all", dOut[0], dOut[1], dOut[2], dOut[3]);
        end
      end
    end
  endtask

  task automatic test_out_reg();
    int validCnt = 0;
    logic [7:0] want;
    for (int c = 0; c < 8; c++) begin
      set_idle();
      if (c < 3) begin we = 1'b1; be = 2'b11; addrIn = 4'(c + 1); dataIn = 8'(c + 1); end
      else if (c < 6) begin oe = 1'b1; addrIn = 4'(c - 2); end
      tick();
      for (int k = 0; k < NINST; k++) begin
        vecCount++;
        if (dOut[k] !== expOut[k] || dValid[k] !== expValid[k] || dBusy[k] !== expBusy) begin
          errCount++;
          $display("FAIL out_reg inst%0d cyc%0d: got out=%h valid=%b busy=%b, want out=%h valid=%b busy=%b",
                   k, cyc, dOut[k], dValid[k], dBusy[k], expOut[k], expValid[k], expBusy);
        end
      end
      if (dValid[3] === 1'b1) validCnt++;
      if (c >= 4 && c <= 6) begin
        want = 8'(c - 3);
        vecCount++;
        if (dOut[3] !== want || dValid[3] !== 1'b1) begin
          errCount++;
          $display("FAIL out_reg_seq step%0d: got out=%h valid=%b, want out=%h valid=1",
                   c, dOut[3], dValid[3], want);
        end
      end
    end
    vecCount++;
    if (validCnt !== 3) begin
      errCount++;
      $display("FAIL out_reg_valid_len: got %0d cycles, want 3", validCnt);
    end
  endtask

  task automatic test_clear_busy();
    int busyCnt = 0;
    for (int c = 0; c < 25; c++) begin
      set_idle();
      case (c)
        0: begin we = 1'b1; be = 2'b11; addrIn = 4'd7; dataIn = 8'h77; end
        1: clr = 1'b1;
        2: begin we = 1'b1; be = 2'b11; addrIn = 4'd7; dataIn = 8'hFF; end
        6: clr = 1'b1;
        23: begin oe = 1'b1; addrIn = 4'd7; end
        default: ;
      endcase
      tick();
      if (dBusy[0] === 1'b1) busyCnt++;
      for (int k = 0; k < NINST; k++) begin
        vecCount++;
        if (dOut[k] !== expOut[k] || dValid[k] !== expValid[k] || dBusy[k] !== expBusy) begin
          errCount++;
          $display("FAIL clear_busy inst%0d cyc%0d: got out=%h valid=%b busy=%b, want out=%h valid=%b busy=%b",
                   k, cyc, dOut[k], dValid[k], dBusy[k], expOut[k], expValid[k], expBusy);
        end
      end
      if (c == 23) begin
        vecCount++;
        if (dOut[0] !== 8'h00 || dValid[0] !== 1'b1) begin
          errCount++;
          $display("FAIL clear_busy_write_ignored: got out=%h valid=%b, want out=00 valid=1",
                   dOut[0], dValid[0]);
        end
      end
    end
    vecCount++;
    if (busyCnt !== 16) begin
      errCount++;
      $display("FAIL clear_busy_len: got %0d cycles, want 16", busyCnt);
    end
  endtask

  task automatic test_reset_mid_clear();
    int busyCnt = 0;
    for (int c = 0; c < 32; c++) begin
      set_idle();
      case (c)
        0: begin we = 1'b1; be = 2'b11; addrIn = 4'd2; dataIn = 8'h5A; end
        1: begin oe = 1'b1; addrIn = 4'd2; end
        2: clr = 1'b1;
        12: rst = 1'b1;
        default: ;
      endcase
      tick();
      if (c >= 12 && dBusy[0] === 1'b1) busyCnt++;
      for (int k = 0; k < NINST; k++) begin
        vecCount++;
        if (dOut[k] !== expOut[k] || dValid[k] !== expValid[k] || dBusy[k] !== expBusy) begin
          errCount++;
          $display("FAIL reset_mid_clear inst%0d cyc%0d: got out=%h valid=%b busy=%b, want out=%h valid=%b busy=%b",
                   k, cyc, dOut[k], dValid[k], dBusy[k], expOut[k], expValid[k], expBusy);
        end
      end
      if (c == 12) begin
        for (int k = 0; k < NINST; k++) begin
          vecCount++;
          if (dOut[k] !== 8'h00 || dValid[k] !== 1'b0 || dBusy[k] !== 1'b1) begin
            errCount++;
            $display("FAIL reset_mid_clear_outputs inst%0d: got out=%h valid=%b busy=%b, want out=00 valid=0 busy=1",
                     k, dOut[k], dValid[k], dBusy[k]);
          end
        end
      end
    end
    vecCount++;
    if (busyCnt !== 16) begin
      errCount++;
      $display("FAIL reset_mid_clear_len: got %0d cycles, want 16", busyCnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(0, 199) == 0);
      clr    = ($urandom_range(0, 39) == 0);
      we     = 1'($urandom);
      oe     = 1'($urandom);
      be     = 2'($urandom);
      addrIn = 4'($urandom);
      dataIn = 8'($urandom);
      tick();
      for (int k = 0; k < NINST; k++) begin
        vecCount++;
        if (dOut[k] !== expOut[k] || dValid[k] !== expValid[k] || dBusy[k] !== expBusy) begin
          errCount++;
          $display("FAIL random inst%0d cyc%0d: got out=%h valid=%b busy=%b, want out=%h valid=%b busy=%b",
                   k, cyc, dOut[k], dValid[k], dBusy[k], expOut[k], expValid[k], expBusy);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1);
  end

  initial begin
    set_idle();
    test_reset();
    test_clear_read();
    test_byte_enable();
    test_rdw();
    test_out_reg();
    test_clear_busy();
    test_reset_mid_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
